vga_timing_gen: RTL

Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Produces the h_cnt/v_cnt/valid triplet that pixel generators consume, plus hsync/vsync for the connector.
- Sits between the top-level clock/reset and every pixel generator in the design.
- Optionally produces a per-frame horizontal scroll position ("border") for scrolling glyph generators.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_pix_div.sv | 54 +++++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared 640x480@60 Hz timing constants and the coordinate type used by the
// raster timing generator and every pixel generator that consumes h/v counts.
//
// Contents:
//   COORD_W        - width of a raster coordinate (10 bits, covers 0..1023)
//   coord_t        - coordinate typedef shared with pixel generators
//   VGA_*          - default timing: divider, porches, sync widths, totals
//   in_span()      - half-open range test lo <= c < hi on a coordinate
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Board clocks per pixel: 100 MHz board clock -> 25 MHz pixel rate.
  localparam int VGA_CLK_DIV = 4;

  localparam int VGA_H_DISP  = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_H_TOTAL = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP; // 800

  localparam int VGA_V_DISP  = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_V_TOTAL = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP; // 525

  // Horizontal scroll ("border") defaults for scrolling glyph generators.
  localparam int VGA_BORDER_MIN  = 48;
  localparam int VGA_BORDER_STEP = 2;

  // Half-open interval test used by every position decode.
  function automatic logic in_span(input coord_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// ---------------------------------------------------------------------------
// vga_pix_div
// Free-running modulo-CLK_DIV divider that produces the pixel-advance strobe.
// pix_tick is registered: it is high for the single clock that follows the
// cycle in which the counter holds CLK_DIV-1, so after reset the first tick
// appears CLK_DIV clocks after rst falls and then repeats every CLK_DIV clocks.
// CLK_DIV must be >= 2.
//
// Ports:
//   clk      - board clock
//   rst      - synchronous reset, active-high
//   pix_tick - one-clock pulse every CLK_DIV clocks
// ---------------------------------------------------------------------------
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

  div_t div_q, div_d;
  logic tick_q, tick_d;

  // NOTE: every variable assigned in always_comb gets a default on the first
  // line of the block; a path that leaves it unassigned would infer a latch.
  always_comb begin
    div_d  = div_q + 1'b1;
    tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign pix_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz raster timing from the 100 MHz board clock. Produces the
// h_cnt/v_cnt/valid triplet for pixel generators and active-low hsync/vsync
// for the connector.
//
// Optional feature (macro VGA_TIMING_BORDER_EN): a per-frame horizontal
// scroll position "border" that steps by BORDER_STEP each frame and reloads
// BORDER_MIN once it would pass H_DISP. Without the macro the border port
// and register do not exist.
//
// Ports:
//   clk         - board clock, 100 MHz
//   rst         - synchronous reset, active-high
//   pix_tick    - one-clock pulse every CLK_DIV clocks (pixel advance)
//   h_cnt       - horizontal position, 0..H_TOTAL-1
//   v_cnt       - vertical position, 0..V_TOTAL-1
//   valid       - (h_cnt, v_cnt) lies in the visible area
//   hsync       - horizontal sync, active-low
//   vsync       - vertical sync, active-low
//   frame_start - one-clock pulse when the raster wraps to (0,0)
//   border      - scroll position (VGA_TIMING_BORDER_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_DISP  = VGA_H_DISP,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_DISP  = VGA_V_DISP,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP
`ifdef VGA_TIMING_BORDER_EN
  ,
  parameter int BORDER_MIN  = VGA_BORDER_MIN,
  parameter int BORDER_STEP = VGA_BORDER_STEP
`endif
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_tick,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               valid,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
`ifdef VGA_TIMING_BORDER_EN
  ,
  output logic [COORD_W-1:0] border
`endif
);

  localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  logic   tick;
  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   valid_q, valid_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   fstart_q, fstart_d;
  logic   frame_wrap;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (tick)
  );

  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    valid_d    = valid_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    frame_wrap = tick && (h_q == H_LAST) && (v_q == V_LAST);

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      // Decodes are taken from the next-state position so they change on the
      // same edge as the counters. They only load on a tick: this keeps the
      // reset value of valid (0) at (0,0) until the raster first moves.
      valid_d = in_span(h_d, 0, H_DISP) && in_span(v_d, 0, V_DISP);
      hsync_d = !in_span(h_d, HS_START, HS_END);
      vsync_d = !in_span(v_d, VS_START, VS_END);
    end

    fstart_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q      <= '0;
      v_q      <= '0;
      valid_q  <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fstart_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      valid_q  <= valid_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fstart_q <= fstart_d;
    end
  end

`ifdef VGA_TIMING_BORDER_EN
  coord_t             border_q, border_d;
  logic [COORD_W:0]   border_sum;

  // One extra bit so the overflow check cannot wrap before the compare.
  always_comb begin
    border_sum = {1'b0, border_q} + (COORD_W + 1)'(BORDER_STEP);
    border_d   = border_q;
    if (frame_wrap) begin
      border_d = (int'(border_sum) > H_DISP) ? coord_t'(BORDER_MIN)
                                             : border_sum[COORD_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      border_q <= coord_t'(BORDER_MIN);
    end else begin
      border_q <= border_d;
    end
  end

  assign border = border_q;
`endif

  assign pix_tick    = tick;
  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fstart_q;

endmodule
